// File: rtl/match_detect_pipe_pkg.sv
// match_detect_pkg: shared types and elaboration helpers for match_detect_pipe.
// Ports: none (package). Provides match_mode_e, MODE_* values, calc_levels()
// and level_width() used to size the OR-reduction tree.
package match_detect_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ZERO = 2'd0,
        MODE_ONES = 2'd1,
        MODE_EQ   = 2'd2,
        MODE_RSVD = 2'd3
    } match_mode_e;

    // Number of FANIN-ary OR levels needed to reduce width bits to one (min 1).
    function automatic int unsigned calc_levels(input int unsigned width, input int unsigned fanin);
        int unsigned lv;
        int unsigned span;
        lv   = 1;
        span = fanin;
        while (span < width) begin
            span = span * fanin;
            lv   = lv + 1;
        end
        return lv;
    endfunction

    // Bit count after 'level' reductions; ceil at each level equals padding to FANIN^LEVELS.
    function automatic int unsigned level_width(input int unsigned width, input int unsigned fanin,
                                                input int unsigned level);
        int unsigned w;
        w = width;
        for (int unsigned i = 0; i < level; i++) begin
            w = (w + fanin - 1) / fanin;
        end
        return w;
    endfunction

endpackage

// File: rtl/match_detect_pipe_if.sv
// match_detect_pipe_if: request/result bundle for match_detect_pipe.
// Request side: in_valid/in_ready handshake, in_mode, in_a, in_b, in_tag, flush.
// Result side:  out_valid/out_ready handshake, out_match, out_tag.
// master = requester/consumer side, slave = the detector.
interface match_detect_pipe_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 6
);
    import match_detect_pkg::*;

    logic              in_valid;
    logic              in_ready;
    match_mode_e       in_mode;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              out_match;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_match, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_tag, flush, out_ready,
        output in_ready, out_valid, out_match, out_tag
    );

endinterface

// File: rtl/match_detect_pipe_or_reduce_level.sv
// or_reduce_level: one combinational level of the OR-reduction tree.
// Ports: in_bits [IN_W] -> out_bits [ceil(IN_W/FANIN)], each output bit is the
// OR of one FANIN-bit group; the last group is zero-padded.
module or_reduce_level #(
    parameter  int unsigned IN_W  = 64,
    parameter  int unsigned FANIN = 4,
    localparam int unsigned OUT_W = (IN_W + FANIN - 1) / FANIN
) (
    input  logic [IN_W-1:0]  in_bits,
    output logic [OUT_W-1:0] out_bits
);

    localparam int unsigned PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] padded_c;

    assign padded_c = PAD_W'(in_bits);

    // Group-wise OR
    always_comb begin
        out_bits = '0;
        for (int unsigned g = 0; g < OUT_W; g++) begin
            out_bits[g] = |padded_c[g*FANIN +: FANIN];
        end
    end

endmodule

// File: rtl/match_detect_pipe.sv
// match_detect_pipe: pipelined zero / all-ones / equality detector.
// Ports: clk, reset (async, active-high), bus (match_detect_pipe_if.slave):
//   request  in_valid/in_ready, in_mode, in_a, in_b, in_tag, flush
//   result   out_valid/out_ready, out_match, out_tag (all registered)
// One register per tree level; all stages advance together when the output
// slot is free or being consumed. Latency is LEVELS cycles.
module match_detect_pipe
    import match_detect_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned FANIN = 4,
    parameter int unsigned TAG_W = 6
) (
    input logic                clk,
    input logic                reset,
    match_detect_pipe_if.slave bus
);

    localparam int unsigned LEVELS = calc_levels(WIDTH, FANIN);
    localparam int unsigned TAGS_W = LEVELS * TAG_W;

    logic                          advance_c;
    logic                          in_ready_c;
    logic                          fire_c;
    logic [WIDTH-1:0]              mism_c;
    logic [LEVELS-1:0]             vld_q;
    logic [LEVELS-1:0][TAG_W-1:0]  tag_q;
    logic                          match_q;

    assign advance_c  = !vld_q[LEVELS-1] || bus.out_ready;
    assign in_ready_c = advance_c && !bus.flush;
    assign fire_c     = bus.in_valid && in_ready_c;

    // Mismatch vector: any set bit means the condition is false
    always_comb begin
        mism_c = '1;
        case (bus.in_mode)
            MODE_ZERO: mism_c = bus.in_a;
            MODE_ONES: mism_c = ~bus.in_a;
            MODE_EQ:   mism_c = bus.in_a ^ bus.in_b;
            default:   mism_c = '1;
        endcase
    end

    // Valid and tag shift registers; flush kills every valid regardless of advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            if (bus.flush) begin
                vld_q <= '0;
            end else if (advance_c) begin
                vld_q <= LEVELS'({vld_q, fire_c});
            end
            if (advance_c) begin
                tag_q <= TAGS_W'({tag_q, bus.in_tag});
            end
        end
    end

    // Reduction tree: combinational level followed by its stage register
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned IN_W  = level_width(WIDTH, FANIN, l);
        localparam int unsigned OUT_W = level_width(WIDTH, FANIN, l + 1);

        logic [IN_W-1:0]  d_c;
        logic [OUT_W-1:0] or_c;

        if (l == 0) begin : g_src
            assign d_c = mism_c;
        end else begin : g_src
            assign d_c = g_lvl[l-1].g_reg.q;
        end

        or_reduce_level #(
            .IN_W  (IN_W),
            .FANIN (FANIN)
        ) u_or (
            .in_bits  (d_c),
            .out_bits (or_c)
        );

        if (l + 1 < LEVELS) begin : g_reg
            logic [OUT_W-1:0] q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q <= '0;
                end else if (advance_c) begin
                    q <= or_c;
                end
            end
        end else begin : g_out
            // Last stage stores the NOR so out_match is a plain register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    match_q <= 1'b0;
                end else if (advance_c) begin
                    match_q <= ~|or_c;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_q[LEVELS-1];
    assign bus.out_match = match_q;
    assign bus.out_tag   = tag_q[LEVELS-1];

endmodule

// File: tb/tb_match_detect_pipe.sv
// tb_match_detect_pipe: drives three detector instances (64/4, 40/4, 16/2) from
// one shared stimulus stream and checks each against a transaction scoreboard
// whose expected results come from a width-masked arithmetic reference.
module tb_match_detect_pipe;
    import match_detect_pkg::*;

    localparam int unsigned TAG_W = 6;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid;
    logic              flush;
    logic              out_ready;
    logic [1:0]        in_mode;
    logic [63:0]       in_a;
    logic [63:0]       in_b;
    logic [TAG_W-1:0]  in_tag;

    logic              ov [3];
    logic              om [3];
    logic [TAG_W-1:0]  ot [3];
    logic              ir [3];

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic              sb_m [3][16];
    logic [TAG_W-1:0]  sb_t [3][16];
    int unsigned       sb_hd [3];
    int unsigned       sb_tl [3];
    int unsigned       acc_cnt [3];
    logic              stall_p [3];
    logic              stall_m [3];
    logic [TAG_W-1:0]  stall_t [3];

    always #5 clk = ~clk;

    match_detect_pipe_if #(.WIDTH(64), .TAG_W(TAG_W)) if64 ();
    match_detect_pipe_if #(.WIDTH(40), .TAG_W(TAG_W)) if40 ();
    match_detect_pipe_if #(.WIDTH(16), .TAG_W(TAG_W)) if16 ();

    assign if64.in_valid = in_valid;  assign if40.in_valid = in_valid;  assign if16.in_valid = in_valid;
    assign if64.flush = flush;        assign if40.flush = flush;        assign if16.flush = flush;
    assign if64.out_ready = out_ready; assign if40.out_ready = out_ready; assign if16.out_ready = out_ready;
    assign if64.in_mode = match_mode_e'(in_mode);
    assign if40.in_mode = match_mode_e'(in_mode);
    assign if16.in_mode = match_mode_e'(in_mode);
    assign if64.in_tag = in_tag;      assign if40.in_tag = in_tag;      assign if16.in_tag = in_tag;
    assign if64.in_a = in_a;          assign if40.in_a = in_a[39:0];    assign if16.in_a = in_a[15:0];
    assign if64.in_b = in_b;          assign if40.in_b = in_b[39:0];    assign if16.in_b = in_b[15:0];

    assign ov[0] = if64.out_valid; assign om[0] = if64.out_match; assign ot[0] = if64.out_tag; assign ir[0] = if64.in_ready;
    assign ov[1] = if40.out_valid; assign om[1] = if40.out_match; assign ot[1] = if40.out_tag; assign ir[1] = if40.in_ready;
    assign ov[2] = if16.out_valid; assign om[2] = if16.out_match; assign ot[2] = if16.out_tag; assign ir[2] = if16.in_ready;

    match_detect_pipe #(.WIDTH(64), .FANIN(4), .TAG_W(TAG_W)) u_dut64 (.clk(clk), .reset(reset), .bus(if64.slave));
    match_detect_pipe #(.WIDTH(40), .FANIN(4), .TAG_W(TAG_W)) u_dut40 (.clk(clk), .reset(reset), .bus(if40.slave));
    match_detect_pipe #(.WIDTH(16), .FANIN(2), .TAG_W(TAG_W)) u_dut16 (.clk(clk), .reset(reset), .bus(if16.slave));

    function automatic int unsigned dut_width(input int k);
        case (k)
            0:       return 64;
            1:       return 40;
            default: return 16;
        endcase
    endfunction

    function automatic int unsigned dut_levels(input int k);
        case (k)
            0:       return 3;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    // Reference: condition evaluated on the low w bits of the operands
    function automatic logic ref_match(input logic [1:0] mode, input logic [63:0] a,
                                       input logic [63:0] b, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (mode)
            2'd0:    return (a & mask) == 64'd0;
            2'd1:    return (a & mask) == mask;
            2'd2:    return ((a ^ b) & mask) == 64'd0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", name, k, obs, exp);
        end
    endtask

    task automatic sb_clear();
        for (int k = 0; k < 3; k++) begin
            sb_hd[k]   = sb_tl[k];
            stall_p[k] = 1'b0;
        end
    endtask

    // One clock: score the cycle at the falling edge, then cross the rising edge
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("in_ready_rule", k, 64'(ir[k]), 64'((!ov[k] || out_ready) && !flush));
            if (stall_p[k]) begin
                chk("hold_valid", k, 64'(ov[k]), 64'd1);
                chk("hold_match", k, 64'(om[k]), 64'(stall_m[k]));
                chk("hold_tag", k, 64'(ot[k]), 64'(stall_t[k]));
            end
            if (ov[k] && out_ready) begin
                chk("out_expected", k, 64'(sb_tl[k] != sb_hd[k]), 64'd1);
                if (sb_tl[k] != sb_hd[k]) begin
                    chk("match", k, 64'(om[k]), 64'(sb_m[k][4'(sb_hd[k])]));
                    chk("tag", k, 64'(ot[k]), 64'(sb_t[k][4'(sb_hd[k])]));
                    sb_hd[k]++;
                end
            end
            stall_p[k] = ov[k] && !out_ready && !flush;
            stall_m[k] = om[k];
            stall_t[k] = ot[k];
            if (flush) begin
                sb_hd[k] = sb_tl[k];
            end else if (in_valid && ir[k]) begin
                sb_m[k][4'(sb_tl[k])] = ref_match(in_mode, in_a, in_b, dut_width(k));
                sb_t[k][4'(sb_tl[k])] = in_tag;
                sb_tl[k]++;
                acc_cnt[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        for (int k = 0; k < 3; k++) chk("drained", k, 64'(sb_tl[k] - sb_hd[k]), 64'd0);
    endtask

    // Single request into empty pipes: latency per instance and explicit result on dut0
    task automatic single(input logic [1:0] mode, input logic [63:0] a, input logic [63:0] b,
                          input logic [TAG_W-1:0] tag, input logic exp_m);
        logic fnd [3];
        int   at0;
        at0 = 0;
        for (int k = 0; k < 3; k++) fnd[k] = 1'b0;
        in_valid = 1'b1; in_mode = mode; in_a = a; in_b = b; in_tag = tag;
        out_ready = 1'b1; flush = 1'b0;
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!fnd[k] && ov[k]) begin
                    fnd[k] = 1'b1;
                    chk("latency", k, 64'(n), 64'(dut_levels(k)));
                    if (k == 0) begin
                        at0 = n;
                        chk("single_match", 0, 64'(om[0]), 64'(exp_m));
                        chk("single_tag", 0, 64'(ot[0]), 64'(tag));
                    end
                end
            end
            if (fnd[0] && n == at0 + 1) chk("single_alone", 0, 64'(ov[0]), 64'd0);
            step();
        end
        for (int k = 0; k < 3; k++) chk("single_seen", k, 64'(fnd[k]), 64'd1);
    endtask

    initial begin
        logic [63:0]  zval [4];
        logic         zexp [4];
        int unsigned  issued;
        int unsigned  base1;
        int unsigned  base2;
        int unsigned  n;
        int unsigned  r;
        logic         acc;

        zval = '{64'd0, 64'd1, 64'h8000_0000_0000_0000, 64'd0};
        zexp = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            sb_hd[k] = 0; sb_tl[k] = 0; acc_cnt[k] = 0;
            stall_p[k] = 1'b0; stall_m[k] = 1'b0; stall_t[k] = '0;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_mode = 2'd0; in_a = '0; in_b = '0; in_tag = '0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", k, 64'(ov[k]), 64'd0);
            chk("reset_match", k, 64'(om[k]), 64'd0);
            chk("reset_tag", k, 64'(ot[k]), 64'd0);
        end
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("ready_after_reset", k, 64'(ir[k]), 64'd1);

        // MODE_ZERO back-to-back, results on consecutive cycles from cycle 3
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_mode = 2'd0; in_a = zval[i]; in_b = '0; in_tag = TAG_W'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 2 && i <= 5) begin
                chk("zero_valid", 0, 64'(ov[0]), 64'd1);
                chk("zero_match", 0, 64'(om[0]), 64'(zexp[i-2]));
                chk("zero_tag", 0, 64'(ot[0]), 64'(i - 1));
            end
            if (i == 6) chk("zero_end", 0, 64'(ov[0]), 64'd0);
        end
        drain();

        // Mode corner cases
        single(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd10, 1'b1);
        single(2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 6'd11, 1'b0);
        single(2'd2, 64'h1234, 64'h1234, 6'd12, 1'b1);
        single(2'd2, 64'h1234, 64'h1235, 6'd13, 1'b0);
        single(2'd3, 64'd0, 64'd0, 6'd14, 1'b0);

        // Flush with three requests in flight and a simultaneous offer
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 2'd1; in_a = '1; in_tag = TAG_W'(5 + i);
            step();
        end
        flush = 1'b1; in_mode = 2'd0; in_a = '0; in_tag = 6'd8;
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) chk("flush_quiet", k, 64'(ov[k]), 64'd0);
            if (i < 2) step();
        end
        single(2'd0, 64'd0, 64'd0, 6'd9, 1'b1);

        // Backpressure: consumer stalls during cycles 4..7
        issued = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (issued < 5);
            in_mode   = 2'd0;
            in_a      = (issued == 2) ? 64'd4 : 64'd0;
            in_tag    = TAG_W'(20 + issued);
            #1;
            acc = in_valid && ir[0];
            if (c >= 4 && c <= 7) chk("bp_in_ready", 0, 64'(ir[0]), 64'd0);
            step();
            if (acc) issued++;
        end
        chk("bp_issued", 0, 64'(issued), 64'd5);
        drain();

        // Asynchronous reset with requests in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mode = 2'd0; in_a = '0; in_tag = TAG_W'(30 + i);
            step();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("midreset_valid", k, 64'(ov[k]), 64'd0);
            chk("midreset_match", k, 64'(om[k]), 64'd0);
            chk("midreset_tag", k, 64'(ot[k]), 64'd0);
        end
        sb_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("ready_after_midreset", k, 64'(ir[k]), 64'd1);
        drain();

        // Randomised sweep, at least 10k accepted requests per narrow instance
        base1 = acc_cnt[1];
        base2 = acc_cnt[2];
        n = 0;
        while (((acc_cnt[1] - base1) < 10000 || (acc_cnt[2] - base2) < 10000) && n < 40000) begin
            in_valid = ($urandom_range(0, 9) != 0);
            in_mode  = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 4);
            case (r)
                0:       in_a = '0;
                1:       in_a = '1;
                2:       in_a = 64'd1 << $urandom_range(0, 63);
                3:       in_a = ~(64'd1 << $urandom_range(0, 63));
                default: in_a = {$urandom, $urandom};
            endcase
            r = $urandom_range(0, 2);
            case (r)
                0:       in_b = in_a;
                1:       in_b = in_a ^ (64'd1 << $urandom_range(0, 63));
                default: in_b = {$urandom, $urandom};
            endcase
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 4) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            step();
            n++;
        end
        chk("sweep_complete", 1, 64'((acc_cnt[1] - base1) >= 10000 && (acc_cnt[2] - base2) >= 10000), 64'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
